rmt_action_issue_ctrl: RTL and testbench

- Per-stage scheduler in front of the RMT action crossbar.
- Pairs each PHV from the match stage with its VLIW action word from the action RAM. The two streams arrive in order, but at independent times.
- Issues each pair to the crossbar as a single-cycle valid pulse.
- Enforces a gap after load/store actions so the stateful 4B ALU memory does not hazard.

---
 rtl/rmt_pkg.sv | 31 +++
 rtl/rmt_sync_fifo.sv | 74 +++++++
 rtl/rmt_action_issue_ctrl.sv | 131 +++++++++++++
 tb/tb_rmt_action_issue_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rmt_pkg.sv
// Shared constants and types for the RMT action issue path: PHV/VLIW geometry,
// sub-action layout and ALU opcodes.
package rmt_pkg;

  localparam int PHV_LEN = 1124;
  localparam int ACT_LEN = 25;
  localparam int ACT_NUM = 25;

  localparam int W_6B = 48;
  localparam int W_4B = 32;
  localparam int W_2B = 16;

  localparam int IDX_6B_BASE = 17;
  localparam int IDX_4B_BASE = 9;
  localparam int IDX_2B_BASE = 1;
  localparam int NUM_4B      = 8;

  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_SUB   = 4'b0010;
  localparam logic [3:0] OP_ADDI  = 4'b1001;
  localparam logic [3:0] OP_SUBI  = 4'b1010;
  localparam logic [3:0] OP_STORE = 4'b1000;
  localparam logic [3:0] OP_LOAD  = 4'b1011;

  typedef enum logic [0:0] {IDLE = 1'b0, GAP = 1'b1} state_e;

  function automatic logic is_ls_op(input logic [3:0] op);
    return (op == OP_STORE) || (op == OP_LOAD);
  endfunction

endpackage

// File: rtl/rmt_sync_fifo.sv
// Small synchronous FIFO with registered full/empty flags and synchronous flush.
// The head entry is visible on rd_data whenever empty is low.
module rmt_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_nxt;
  logic             wr_fire;
  logic             rd_fire;

  // A full FIFO refuses writes even when a read frees a slot in the same cycle.
  assign wr_fire = wr_en && !full && !flush;
  assign rd_fire = rd_en && !empty && !flush;

  always_comb begin
    count_nxt = count;
    if (flush) begin
      count_nxt = '0;
    end else begin
      case ({wr_fire, rd_fire})
        2'b10:   count_nxt = count + CW'(1);
        2'b01:   count_nxt = count - CW'(1);
        default: count_nxt = count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_fire) wr_ptr <= wr_ptr + AW'(1);
        if (rd_fire) rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  // NOTE: storage has no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/rmt_action_issue_ctrl.sv
// Pairs match-stage PHVs with action-RAM VLIW words and issues each pair to the
// action crossbar, inserting idle cycles after load/store actions.
module rmt_action_issue_ctrl #(
  parameter int PHV_LEN    = rmt_pkg::PHV_LEN,
  parameter int ACT_LEN    = rmt_pkg::ACT_LEN,
  parameter int ACT_NUM    = rmt_pkg::ACT_NUM,
  parameter int FIFO_DEPTH = 4,
  parameter int LS_GAP     = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [PHV_LEN-1:0]         phv_in,
  input  logic                       phv_in_valid,
  output logic                       phv_in_ready,
  input  logic [ACT_LEN*ACT_NUM-1:0] action_in,
  input  logic                       action_in_valid,
  output logic                       action_in_ready,
  input  logic                       alu_ready,
  input  logic                       flush,
  output logic [PHV_LEN-1:0]         phv_out,
  output logic [ACT_LEN*ACT_NUM-1:0] action_out,
  output logic                       out_valid,
  output logic [31:0]                pair_cnt,
  output logic [15:0]                gap_stall_cnt
);

  import rmt_pkg::*;

  localparam int AW = ACT_LEN * ACT_NUM;
  localparam int GW = (LS_GAP > 2) ? $clog2(LS_GAP) : 1;

  localparam logic [0:0] ST_IDLE = IDLE;
  localparam logic [0:0] ST_GAP  = GAP;

  logic [PHV_LEN-1:0] phv_head;
  logic [AW-1:0]      act_head;
  logic               phv_full;
  logic               phv_empty;
  logic               act_full;
  logic               act_empty;
  logic [0:0]         state;
  logic [GW-1:0]      gap_cnt;
  logic               issue;
  logic               head_is_ls;
  logic               pair_ready;

  rmt_sync_fifo #(.WIDTH(PHV_LEN), .DEPTH(FIFO_DEPTH)) u_phv_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .wr_en   (phv_in_valid),
    .wr_data (phv_in),
    .rd_en   (issue),
    .rd_data (phv_head),
    .full    (phv_full),
    .empty   (phv_empty)
  );

  rmt_sync_fifo #(.WIDTH(AW), .DEPTH(FIFO_DEPTH)) u_act_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .wr_en   (action_in_valid),
    .wr_data (action_in),
    .rd_en   (issue),
    .rd_data (act_head),
    .full    (act_full),
    .empty   (act_empty)
  );

  assign phv_in_ready    = !phv_full;
  assign action_in_ready = !act_full;

  assign pair_ready = !phv_empty && !act_empty;
  assign issue      = pair_ready && alu_ready && (state == ST_IDLE) && !flush;

  // Only the 4B sub-actions drive the stateful ALU memory.
  always_comb begin
    head_is_ls = 1'b0;
    for (int i = IDX_4B_BASE; i < IDX_4B_BASE + NUM_4B; i++) begin
      if (is_ls_op(act_head[ACT_LEN*i + ACT_LEN-1 -: 4])) head_is_ls = 1'b1;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      gap_cnt       <= '0;
      out_valid     <= 1'b0;
      phv_out       <= '0;
      action_out    <= '0;
      pair_cnt      <= '0;
      gap_stall_cnt <= '0;
    end else begin
      out_valid <= issue;
      if (issue) begin
        phv_out    <= phv_head;
        action_out <= act_head;
        pair_cnt   <= pair_cnt + 32'd1;
      end

      if ((state == ST_GAP) && pair_ready && (gap_stall_cnt != 16'hFFFF))
        gap_stall_cnt <= gap_stall_cnt + 16'd1;

      if (flush) begin
        state   <= ST_IDLE;
        gap_cnt <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (issue && head_is_ls && (LS_GAP > 0)) begin
              state   <= ST_GAP;
              gap_cnt <= GW'(LS_GAP - 1);
            end
          end
          ST_GAP: begin
            // A stalled crossbar freezes the gap countdown as well.
            if (alu_ready) begin
              if (gap_cnt == '0) state <= ST_IDLE;
              else               gap_cnt <= gap_cnt - GW'(1);
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rmt_action_issue_ctrl.sv
// Bench for rmt_action_issue_ctrl: directed table, hand-written corner sequences
// and a randomized run, all compared against a queue-based reference model.
module tb_rmt_action_issue_ctrl;

  import rmt_pkg::*;

  localparam int DEPTH = 4;
  localparam int LSG   = 2;
  localparam int AWID  = ACT_LEN * ACT_NUM;

  typedef logic [PHV_LEN-1:0] phv_t;
  typedef logic [AWID-1:0]    act_t;

  typedef struct {
    bit pv;
    bit av;
    bit ar;
    bit fl;
    bit ov;
    bit prdy;
    bit ardy;
  } vec_t;

  logic        clk;
  logic        rst_n;
  phv_t        phv_in;
  logic        phv_in_valid;
  logic        phv_in_ready;
  act_t        action_in;
  logic        action_in_valid;
  logic        action_in_ready;
  logic        alu_ready;
  logic        flush;
  phv_t        phv_out;
  act_t        action_out;
  logic        out_valid;
  logic [31:0] pair_cnt;
  logic [15:0] gap_stall_cnt;

  rmt_action_issue_ctrl #(
    .PHV_LEN(PHV_LEN), .ACT_LEN(ACT_LEN), .ACT_NUM(ACT_NUM),
    .FIFO_DEPTH(DEPTH), .LS_GAP(LSG)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .phv_in          (phv_in),
    .phv_in_valid    (phv_in_valid),
    .phv_in_ready    (phv_in_ready),
    .action_in       (action_in),
    .action_in_valid (action_in_valid),
    .action_in_ready (action_in_ready),
    .alu_ready       (alu_ready),
    .flush           (flush),
    .phv_out         (phv_out),
    .action_out      (action_out),
    .out_valid       (out_valid),
    .pair_cnt        (pair_cnt),
    .gap_stall_cnt   (gap_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state: queues of buffered beats plus remaining gap cycles.
  phv_t        m_phv_q[$];
  act_t        m_act_q[$];
  int          m_gap;
  bit          m_ov;
  phv_t        m_phv_out;
  act_t        m_act_out;
  logic [31:0] m_pair;
  logic [15:0] m_stall;
  phv_t        drv_phv;

  vec_t vt[17];

  task automatic check(input string name, input bit ok,
                       input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phv_q.delete();
    m_act_q.delete();
    m_gap     = 0;
    m_ov      = 1'b0;
    m_phv_out = '0;
    m_act_out = '0;
    m_pair    = '0;
    m_stall   = '0;
  endtask

  function automatic bit act_is_ls(input act_t a);
    logic [3:0] op;
    for (int i = 9; i <= 16; i++) begin
      op = a[ACT_LEN*i + 21 +: 4];
      if (op == OP_LOAD || op == OP_STORE) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic phv_t rand_phv();
    logic [36*32-1:0] raw;
    for (int i = 0; i < 36; i++) raw[i*32 +: 32] = $urandom;
    return raw[PHV_LEN-1:0];
  endfunction

  // mode 0: plain 4B opcodes, 1: one random 4B slot load/store,
  // 2: fully random bits, 3: sub-action 10 is a load, rest plain
  function automatic act_t rand_act(input int mode);
    logic [20*32-1:0] raw;
    logic [3:0]       safe [5];
    act_t             a;
    safe = '{4'b0000, OP_ADD, OP_SUB, OP_ADDI, OP_SUBI};
    for (int i = 0; i < 20; i++) raw[i*32 +: 32] = $urandom;
    a = raw[AWID-1:0];
    if (mode != 2) begin
      for (int i = 9; i <= 16; i++) a[ACT_LEN*i + 21 +: 4] = safe[$urandom_range(0, 4)];
    end
    if (mode == 1)
      a[ACT_LEN*$urandom_range(9, 16) + 21 +: 4] = ($urandom_range(0, 1) != 0) ? OP_LOAD : OP_STORE;
    if (mode == 3) a[ACT_LEN*10 + 21 +: 4] = OP_LOAD;
    return a;
  endfunction

  task automatic compare_all();
    check("out_valid", out_valid === m_ov, 64'(out_valid), 64'(m_ov));
    check("phv_out", phv_out === m_phv_out, phv_out[63:0], m_phv_out[63:0]);
    check("action_out", action_out === m_act_out, action_out[63:0], m_act_out[63:0]);
    check("pair_cnt", pair_cnt === m_pair, 64'(pair_cnt), 64'(m_pair));
    check("gap_stall_cnt", gap_stall_cnt === m_stall, 64'(gap_stall_cnt), 64'(m_stall));
    check("phv_in_ready", phv_in_ready === (m_phv_q.size() < DEPTH),
          64'(phv_in_ready), 64'(m_phv_q.size() < DEPTH));
    check("action_in_ready", action_in_ready === (m_act_q.size() < DEPTH),
          64'(action_in_ready), 64'(m_act_q.size() < DEPTH));
  endtask

  // Drive one cycle of inputs, advance past the edge, update the model, compare.
  task automatic step(input bit pv, input bit av, input bit ar, input bit fl, input int mode);
    phv_t p;
    act_t a;
    bit   p_rdy;
    bit   a_rdy;
    bit   iss;
    p               = rand_phv();
    a               = rand_act(mode);
    drv_phv         = p;
    phv_in          = p;
    action_in       = a;
    phv_in_valid    = pv;
    action_in_valid = av;
    alu_ready       = ar;
    flush           = fl;
    p_rdy = m_phv_q.size() < DEPTH;
    a_rdy = m_act_q.size() < DEPTH;
    iss   = (m_phv_q.size() > 0) && (m_act_q.size() > 0) && ar && (m_gap == 0) && !fl;
    @(posedge clk);
    #1;
    if (m_gap > 0 && m_phv_q.size() > 0 && m_act_q.size() > 0 && m_stall != 16'hFFFF)
      m_stall++;
    if (fl) begin
      m_phv_q.delete();
      m_act_q.delete();
      m_gap = 0;
    end else begin
      if (m_gap > 0 && ar) m_gap--;
      if (iss) begin
        m_phv_out = m_phv_q.pop_front();
        m_act_out = m_act_q.pop_front();
        m_pair++;
        if (act_is_ls(m_act_out) && LSG > 0) m_gap = LSG;
      end
      if (pv && p_rdy) m_phv_q.push_back(p);
      if (av && a_rdy) m_act_q.push_back(a);
    end
    m_ov = iss;
    compare_all();
  endtask

  task automatic idle_inputs();
    phv_in_valid    = 1'b0;
    action_in_valid = 1'b0;
    flush           = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    phv_t t1_phv;
    phv_t p_new;
    bit   seq_ov [7];

    // pv av ar fl | ov prdy ardy
    vt[0]  = '{1, 0, 1, 0, 0, 1, 1};
    vt[1]  = '{0, 0, 1, 0, 0, 1, 1};
    vt[2]  = '{0, 0, 1, 0, 0, 1, 1};
    vt[3]  = '{0, 1, 1, 0, 0, 1, 1};
    vt[4]  = '{0, 0, 1, 0, 1, 1, 1};
    vt[5]  = '{0, 0, 1, 0, 0, 1, 1};
    vt[6]  = '{1, 1, 0, 0, 0, 1, 1};
    vt[7]  = '{1, 1, 0, 0, 0, 1, 1};
    vt[8]  = '{1, 1, 0, 0, 0, 1, 1};
    vt[9]  = '{1, 1, 0, 0, 0, 0, 0};
    vt[10] = '{1, 0, 0, 0, 0, 0, 0};
    vt[11] = '{1, 0, 1, 0, 1, 1, 1};
    vt[12] = '{1, 0, 1, 0, 1, 1, 1};
    vt[13] = '{0, 0, 1, 0, 1, 1, 1};
    vt[14] = '{0, 0, 1, 0, 1, 1, 1};
    vt[15] = '{0, 0, 1, 0, 0, 1, 1};
    vt[16] = '{1, 1, 1, 1, 0, 1, 1};

    rst_n     = 1'b0;
    phv_in    = '0;
    action_in = '0;
    alu_ready = 1'b0;
    idle_inputs();
    model_reset();
    #12;
    check("reset_out_valid", out_valid === 1'b0, 64'(out_valid), 64'd0);
    check("reset_pair_cnt", pair_cnt === 32'd0, 64'(pair_cnt), 64'd0);
    check("reset_stall_cnt", gap_stall_cnt === 16'd0, 64'(gap_stall_cnt), 64'd0);
    check("reset_phv_out", phv_out === '0, phv_out[63:0], 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_phv_ready", phv_in_ready === 1'b1, 64'(phv_in_ready), 64'd1);
    check("reset_act_ready", action_in_ready === 1'b1, 64'(action_in_ready), 64'd1);

    // Table: single-pair latency, back-pressure fill and drain, flush
    for (int i = 0; i < 17; i++) begin
      step(vt[i].pv, vt[i].av, vt[i].ar, vt[i].fl, 0);
      if (i == 0) t1_phv = drv_phv;
      check($sformatf("vec%0d_ov", i), out_valid === vt[i].ov, 64'(out_valid), 64'(vt[i].ov));
      check($sformatf("vec%0d_prdy", i), phv_in_ready === vt[i].prdy,
            64'(phv_in_ready), 64'(vt[i].prdy));
      check($sformatf("vec%0d_ardy", i), action_in_ready === vt[i].ardy,
            64'(action_in_ready), 64'(vt[i].ardy));
      if (i == 4) check("t1_phv_out", phv_out === t1_phv, phv_out[63:0], t1_phv[63:0]);
    end
    check("table_pair_cnt", pair_cnt === 32'd5, 64'(pair_cnt), 64'd5);

    // Four pairs back-to-back: pulses on four consecutive edges
    seq_ov = '{0, 1, 1, 1, 1, 0, 0};
    for (int i = 0; i < 6; i++) begin
      step(i < 4, i < 4, 1'b1, 1'b0, 0);
      check($sformatf("b2b_ov%0d", i), out_valid === seq_ov[i], 64'(out_valid), 64'(seq_ov[i]));
    end
    check("b2b_pair_cnt", pair_cnt === 32'd9, 64'(pair_cnt), 64'd9);

    // Load in sub-action 10 forces two idle cycles before the next pair
    seq_ov = '{0, 1, 0, 0, 1, 1, 0};
    for (int i = 0; i < 7; i++) begin
      step(i < 3, i < 3, 1'b1, 1'b0, (i == 0) ? 3 : 0);
      check($sformatf("gap_ov%0d", i), out_valid === seq_ov[i], 64'(out_valid), 64'(seq_ov[i]));
    end
    check("gap_stall_cnt_2", gap_stall_cnt === 16'd2, 64'(gap_stall_cnt), 64'd2);
    check("gap_pair_cnt", pair_cnt === 32'd12, 64'(pair_cnt), 64'd12);

    // Flush discards buffered PHVs; a lone action then waits for a fresh PHV
    step(1, 0, 1, 0, 0);
    step(1, 0, 1, 0, 0);
    step(1, 1, 1, 1, 0);
    step(0, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 0, 0);
      check($sformatf("flush_no_issue%0d", i), out_valid === 1'b0, 64'(out_valid), 64'd0);
    end
    step(1, 0, 1, 0, 0);
    p_new = drv_phv;
    step(0, 0, 1, 0, 0);
    check("flush_new_issue", out_valid === 1'b1, 64'(out_valid), 64'd1);
    check("flush_new_phv", phv_out === p_new, phv_out[63:0], p_new[63:0]);

    // Asynchronous reset while in GAP with three pairs buffered
    step(1, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    check("rst_pre_issue", out_valid === 1'b1, 64'(out_valid), 64'd1);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_async_ov", out_valid === 1'b0, 64'(out_valid), 64'd0);
    check("rst_async_pair", pair_cnt === 32'd0, 64'(pair_cnt), 64'd0);
    check("rst_async_phv", phv_out === '0, phv_out[63:0], 64'd0);
    idle_inputs();
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(0, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 0, 0);
      check($sformatf("rst_empty%0d", i), out_valid === 1'b0, 64'(out_valid), 64'd0);
    end
    step(1, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    check("rst_fresh_issue", out_valid === 1'b1, 64'(out_valid), 64'd1);
    check("rst_fresh_pair", pair_cnt === 32'd1, 64'(pair_cnt), 64'd1);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = $urandom_range(0, 3);
      step(($urandom % 4) != 0, ($urandom % 4) != 0, ($urandom % 10) < 7,
           ($urandom % 50) == 0, (r < 2) ? 0 : (r == 2) ? 1 : 2);
    end

    idle_inputs();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
